// File: rtl/inv_sbox_iter.sv
// Iterative AES inverse S-box: inverse affine, then x^254 in GF(2^8) by square-and-multiply.
// Define INV_SBOX_FWD_EN to add a mode input that selects the forward S-box instead.
module inv_sbox_iter #(
    parameter logic [7:0] INV_C = 8'h05
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] i,
`ifdef INV_SBOX_FWD_EN
    input  logic       mode,
`endif
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] q
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] sq_q, sq_d;
    logic [7:0] acc_q, acc_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] q_q, q_d;

    logic [7:0] in_byte;
    logic [7:0] sq_sq;
    logic [7:0] acc_next;
    logic [7:0] result;

    // Shift-and-add multiply, reducing by 0x11B whenever the shifted operand overflows
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int k = 0; k < 8; k++) begin
            if (y[k]) begin
                p = p ^ t;
            end
            t = t[7] ? ({t[6:0], 1'b0} ^ 8'h1B) : {t[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        logic [7:0] a;
        for (int k = 0; k < 8; k++) begin
            a[k] = x[(k + 2) % 8] ^ x[(k + 5) % 8] ^ x[(k + 7) % 8] ^ INV_C[k];
        end
        return a;
    endfunction

`ifdef INV_SBOX_FWD_EN
    logic mode_q, mode_d;

    function automatic logic [7:0] fwd_affine(input logic [7:0] b);
        logic [7:0] c;
        logic [7:0] fwd_c;
        fwd_c = 8'h63;
        for (int k = 0; k < 8; k++) begin
            c[k] = b[k] ^ b[(k + 4) % 8] ^ b[(k + 5) % 8] ^ b[(k + 6) % 8]
                 ^ b[(k + 7) % 8] ^ fwd_c[k];
        end
        return c;
    endfunction

    assign in_byte = mode ? i : inv_affine(i);
    assign result  = mode_q ? fwd_affine(acc_next) : acc_next;
`else
    assign in_byte = inv_affine(i);
    assign result  = acc_next;
`endif

    assign sq_sq    = gf_mul(sq_q, sq_q);
    assign acc_next = gf_mul(acc_q, sq_sq);

    always_comb begin
        state_d = state_q;
        sq_d    = sq_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
`ifdef INV_SBOX_FWD_EN
        mode_d  = mode_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sq_d    = in_byte;
                    acc_d   = 8'h01;
                    cnt_d   = 3'd0;
                    state_d = CALC;
`ifdef INV_SBOX_FWD_EN
                    mode_d  = mode;
`endif
                end
            end
            CALC: begin
                // Seven squarings accumulate exponents 2+4+...+128 = 254
                sq_d  = sq_sq;
                acc_d = acc_next;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd6) begin
                    q_d     = result;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sq_q    <= 8'h00;
            acc_q   <= 8'h01;
            cnt_q   <= 3'd0;
            q_q     <= 8'h00;
`ifdef INV_SBOX_FWD_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sq_q    <= sq_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
`ifdef INV_SBOX_FWD_EN
            mode_q  <= mode_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign q         = q_q;

endmodule
